user_reg_initiator: RTL and testbench

Host-side initiator for the user register interface. Accepts single register read/write requests from the PCIe target path and converts each into a one-cycle `wr_req`/`rd_req` pulse toward user logic. For reads, it waits for `rd_ack` (bounded by a timeout) and returns one completion upstream. Sits between the PCIe request decoder and the user logic wrapper, all in the PCIe clock domain.

---
 rtl/user_reg_pkg.sv | 23 ++
 rtl/user_reg_initiator_if.sv | 46 ++++
 rtl/user_reg_initiator.sv | 138 +++++++++++++
 tb/tb_user_reg_initiator.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_reg_pkg.sv
// Shared types and constants for the user register initiator: FSM encoding,
// default bus widths and the data word returned on a read timeout.
package user_reg_pkg;

    localparam int DEFAULT_ADDR_W = 20;
    localparam int DEFAULT_DATA_W = 32;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_CPL
    } state_e;

    // Saturating increment for the 16-bit timed-out read counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/user_reg_initiator_if.sv
// Host request/completion and user register bus bundle for the initiator.
// The master modport is the initiator's view; slave is the host plus user logic.
interface user_reg_initiator_if
    import user_reg_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) ();

    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_wr;
    logic [ADDR_W-1:0] i_req_addr;
    logic [DATA_W-1:0] i_req_data;

    logic              o_cpl_valid;
    logic              i_cpl_ready;
    logic [DATA_W-1:0] o_cpl_data;
    logic              o_cpl_timeout;

    logic [ADDR_W-1:0] o_user_addr;
    logic [DATA_W-1:0] o_user_data;
    logic              o_user_wr_req;
    logic              o_user_rd_req;
    logic [DATA_W-1:0] i_user_data;
    logic              i_user_rd_ack;

    logic [15:0]       o_timeout_cnt;

    modport master (
        input  i_req_valid, i_req_wr, i_req_addr, i_req_data,
        input  i_cpl_ready, i_user_data, i_user_rd_ack,
        output o_req_ready, o_cpl_valid, o_cpl_data, o_cpl_timeout,
        output o_user_addr, o_user_data, o_user_wr_req, o_user_rd_req,
        output o_timeout_cnt
    );

    modport slave (
        output i_req_valid, i_req_wr, i_req_addr, i_req_data,
        output i_cpl_ready, i_user_data, i_user_rd_ack,
        input  o_req_ready, o_cpl_valid, o_cpl_data, o_cpl_timeout,
        input  o_user_addr, o_user_data, o_user_wr_req, o_user_rd_req,
        input  o_timeout_cnt
    );

endinterface

// File: rtl/user_reg_initiator.sv
// Turns single host register requests into one-cycle user strobes and returns
// one completion per read, substituting a marker word if rd_ack never arrives.
module user_reg_initiator
    import user_reg_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = 256
) (
    input  logic                 i_pcie_clk,
    input  logic                 i_rst,
    user_reg_initiator_if.master bus
);

    localparam int                 TIMER_W    = $clog2(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [ADDR_W-1:0]   user_addr_q, user_addr_d;
    logic [DATA_W-1:0]   user_data_q, user_data_d;
    logic [DATA_W-1:0]   cpl_data_q, cpl_data_d;
    logic                cpl_timeout_q, cpl_timeout_d;
    logic [15:0]         timeout_cnt_q, timeout_cnt_d;

    logic                req_ready;
    logic                user_wr_req;
    logic                user_rd_req;
    logic                cpl_valid;

    // NOTE: reset is synchronous and every register, including the captured
    // data words, is cleared so an aborted read leaves nothing visible.
    always_ff @(posedge i_pcie_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            user_addr_q   <= '0;
            user_data_q   <= '0;
            cpl_data_q    <= '0;
            cpl_timeout_q <= 1'b0;
            timeout_cnt_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment only; all
            // next-state arithmetic lives in the combinational block below.
            state_q       <= state_d;
            timer_q       <= timer_d;
            user_addr_q   <= user_addr_d;
            user_data_q   <= user_data_d;
            cpl_data_q    <= cpl_data_d;
            cpl_timeout_q <= cpl_timeout_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a hold/idle default first so
        // no path through the case statement can infer a latch.
        state_d       = state_q;
        timer_d       = timer_q;
        user_addr_d   = user_addr_q;
        user_data_d   = user_data_q;
        cpl_data_d    = cpl_data_q;
        cpl_timeout_d = cpl_timeout_q;
        timeout_cnt_d = timeout_cnt_q;
        req_ready     = 1'b0;
        user_wr_req   = 1'b0;
        user_rd_req   = 1'b0;
        cpl_valid     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                timer_d   = '0;
                if (bus.i_req_valid) begin
                    user_addr_d = bus.i_req_addr;
                    user_data_d = bus.i_req_data;
                    state_d     = bus.i_req_wr ? ST_WR : ST_RD_REQ;
                end
            end

            ST_WR: begin
                user_wr_req = 1'b1;
                state_d     = ST_IDLE;
            end

            ST_RD_REQ: begin
                user_rd_req = 1'b1;
                timer_d     = timer_q + 1'b1;
                if (bus.i_user_rd_ack) begin
                    cpl_data_d    = bus.i_user_data;
                    cpl_timeout_d = 1'b0;
                    state_d       = ST_CPL;
                end else begin
                    state_d = ST_RD_WAIT;
                end
            end

            ST_RD_WAIT: begin
                // Ack is tested first so it wins over a coincident expiry.
                if (bus.i_user_rd_ack) begin
                    cpl_data_d    = bus.i_user_data;
                    cpl_timeout_d = 1'b0;
                    state_d       = ST_CPL;
                end else if (timer_q == TIMER_LAST) begin
                    cpl_data_d    = DATA_W'(TIMEOUT_DATA);
                    cpl_timeout_d = 1'b1;
                    timeout_cnt_d = sat_inc16(timeout_cnt_q);
                    state_d       = ST_CPL;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_CPL: begin
                cpl_valid = 1'b1;
                if (bus.i_cpl_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ready is masked by reset so nothing is accepted while reset is held.
    assign bus.o_req_ready   = req_ready & ~i_rst;
    assign bus.o_cpl_valid   = cpl_valid;
    assign bus.o_cpl_data    = cpl_data_q;
    assign bus.o_cpl_timeout = cpl_timeout_q;
    assign bus.o_user_addr   = user_addr_q;
    assign bus.o_user_data   = user_data_q;
    assign bus.o_user_wr_req = user_wr_req;
    assign bus.o_user_rd_req = user_rd_req;
    assign bus.o_timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_user_reg_initiator.sv
// Scoreboard bench for user_reg_initiator: writes, acked and timed-out reads,
// completion backpressure and reset in the middle of a read.
module tb_user_reg_initiator;

    localparam int ADDR_W  = 20;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              timeout;
        int                lat;
    } exp_cpl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_to_cnt = 16'd0;
    exp_cpl_t    sb[$];

    always #2 clk = ~clk;

    user_reg_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    user_reg_initiator #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_pcie_clk(clk),
        .i_rst     (rst),
        .bus       (bus)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({bus.o_cpl_valid, bus.o_user_wr_req, bus.o_user_rd_req} !== 3'b000) begin
            errors++;
            $display("FAIL %s: cpl_valid/wr_req/rd_req=%b%b%b expected 000", name,
                     bus.o_cpl_valid, bus.o_user_wr_req, bus.o_user_rd_req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.o_req_ready, bus.o_cpl_valid, bus.o_user_wr_req, bus.o_user_rd_req,
             bus.o_cpl_timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready,cpl_valid,wr,rd,timeout=%b%b%b%b%b expected 00000",
                     bus.o_req_ready, bus.o_cpl_valid, bus.o_user_wr_req,
                     bus.o_user_rd_req, bus.o_cpl_timeout);
        end
        checks++;
        if (bus.o_cpl_data !== 32'h0 || bus.o_user_addr !== 20'h0 || bus.o_user_data !== 32'h0
            || bus.o_timeout_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: cpl_data=%h addr=%h data=%h cnt=%h expected all 0",
                     bus.o_cpl_data, bus.o_user_addr, bus.o_user_data, bus.o_timeout_cnt);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", bus.o_req_ready);
        end
        check_idle_outputs("reset_release_idle");
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        bus.i_req_valid = 1'b1;
        bus.i_req_wr    = 1'b1;
        bus.i_req_addr  = addr;
        bus.i_req_data  = data;
        checks++;
        if (bus.o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_accept: ready=%b expected 1", bus.o_req_ready);
        end
        tick();
        bus.i_req_valid = 1'b0;
        bus.i_req_addr  = ~addr;
        bus.i_req_data  = ~data;
        checks++;
        if (bus.o_user_wr_req !== 1'b1 || bus.o_user_rd_req !== 1'b0 || bus.o_cpl_valid !== 1'b0
            || bus.o_user_addr !== addr || bus.o_user_data !== data) begin
            errors++;
            $display("FAIL wr_strobe: wr=%b rd=%b cpl=%b addr=%h data=%h expected 1 0 0 %h %h",
                     bus.o_user_wr_req, bus.o_user_rd_req, bus.o_cpl_valid,
                     bus.o_user_addr, bus.o_user_data, addr, data);
        end
        tick();
        check_idle_outputs("wr_after_strobe");
        checks++;
        if (bus.o_req_ready !== 1'b1 || bus.o_user_addr !== addr || bus.o_user_data !== data) begin
            errors++;
            $display("FAIL wr_hold: ready=%b addr=%h data=%h expected 1 %h %h",
                     bus.o_req_ready, bus.o_user_addr, bus.o_user_data, addr, data);
        end
    endtask

    task automatic test_write();
        do_write(20'h00010, 32'hA5A5_0001);
        repeat (3) begin
            tick();
            check_idle_outputs("wr_no_cpl");
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        bus.i_req_valid = 1'b1;
        bus.i_req_wr    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.i_req_addr = 20'h00100 + 20'(i);
            bus.i_req_data = 32'hB000_0000 + 32'(i);
            checks++;
            if (bus.o_req_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got %b expected 1", i, bus.o_req_ready);
            end
            tick();
            if (i == 3) bus.i_req_valid = 1'b0;
            if (bus.o_user_wr_req === 1'b1) pulses++;
            checks++;
            if (bus.o_user_wr_req !== 1'b1 || bus.o_req_ready !== 1'b0
                || bus.o_user_addr !== 20'h00100 + 20'(i)) begin
                errors++;
                $display("FAIL b2b_strobe[%0d]: wr=%b ready=%b addr=%h expected 1 0 %h", i,
                         bus.o_user_wr_req, bus.o_req_ready, bus.o_user_addr,
                         20'h00100 + 20'(i));
            end
            tick();
        end
        checks++;
        if (pulses != 4 || bus.o_user_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count: pulses=%0d wr=%b expected 4 0", pulses, bus.o_user_wr_req);
        end
    endtask

    // ack_delay: cycles after rd_req at which rd_ack is driven; -1 means never.
    task automatic run_read(input logic [ADDR_W-1:0] addr, input int ack_delay,
                            input logic [DATA_W-1:0] ack_data, input int hold);
        exp_cpl_t e;
        exp_cpl_t got;
        int       lat = -1;
        int       extra_rd = 0;
        int       wr_seen = 0;

        if (ack_delay >= 0 && ack_delay < TIMEOUT) begin
            e.data    = ack_data;
            e.timeout = 1'b0;
            e.lat     = ack_delay + 1;
        end else begin
            e.data    = 32'hDEAD_BEEF;
            e.timeout = 1'b1;
            e.lat     = TIMEOUT;
            if (exp_to_cnt != 16'hFFFF) exp_to_cnt = exp_to_cnt + 16'd1;
        end
        sb.push_back(e);

        bus.i_req_valid = 1'b1;
        bus.i_req_wr    = 1'b0;
        bus.i_req_addr  = addr;
        bus.i_req_data  = $urandom;
        checks++;
        if (bus.o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rd_accept: ready=%b expected 1", bus.o_req_ready);
        end
        tick();
        bus.i_req_valid = 1'b0;
        checks++;
        if (bus.o_user_rd_req !== 1'b1 || bus.o_user_wr_req !== 1'b0 || bus.o_user_addr !== addr) begin
            errors++;
            $display("FAIL rd_strobe: rd=%b wr=%b addr=%h expected 1 0 %h",
                     bus.o_user_rd_req, bus.o_user_wr_req, bus.o_user_addr, addr);
        end

        for (int k = 0; k < TIMEOUT + 8; k++) begin
            if (k > 0 && bus.o_cpl_valid === 1'b1) begin
                lat = k;
                break;
            end
            if (k > 0 && bus.o_user_rd_req !== 1'b0) extra_rd++;
            bus.i_user_rd_ack = (k == ack_delay);
            bus.i_user_data   = (k == ack_delay) ? ack_data : DATA_W'($urandom);
            tick();
        end
        bus.i_user_rd_ack = 1'b0;

        got = sb.pop_front();
        checks++;
        if (lat != got.lat) begin
            errors++;
            $display("FAIL rd_latency: cpl after %0d cycles expected %0d", lat, got.lat);
        end
        checks++;
        if (bus.o_cpl_data !== got.data || bus.o_cpl_timeout !== got.timeout) begin
            errors++;
            $display("FAIL rd_cpl: data=%h timeout=%b expected %h %b",
                     bus.o_cpl_data, bus.o_cpl_timeout, got.data, got.timeout);
        end
        checks++;
        if (extra_rd != 0) begin
            errors++;
            $display("FAIL rd_single_strobe: %0d extra rd_req cycles expected 0", extra_rd);
        end

        for (int h = 0; h < hold; h++) begin
            checks++;
            if (bus.o_cpl_valid !== 1'b1 || bus.o_cpl_data !== got.data
                || bus.o_cpl_timeout !== got.timeout || bus.o_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL cpl_hold[%0d]: valid=%b data=%h to=%b ready=%b expected 1 %h %b 0",
                         h, bus.o_cpl_valid, bus.o_cpl_data, bus.o_cpl_timeout,
                         bus.o_req_ready, got.data, got.timeout);
            end
            bus.i_req_valid   = 1'b1;
            bus.i_req_wr      = 1'b1;
            bus.i_req_addr    = 20'h00099;
            bus.i_req_data    = 32'hCAFE_0099;
            bus.i_user_rd_ack = (h == 2);
            bus.i_user_data   = 32'h5555_5555;
            tick();
            if (bus.o_user_wr_req !== 1'b0) wr_seen++;
        end
        bus.i_user_rd_ack = 1'b0;

        bus.i_cpl_ready = 1'b1;
        tick();
        bus.i_cpl_ready = 1'b0;
        checks++;
        if (bus.o_cpl_valid !== 1'b0 || bus.o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL cpl_release: valid=%b ready=%b expected 0 1",
                     bus.o_cpl_valid, bus.o_req_ready);
        end

        if (hold > 0) begin
            checks++;
            if (wr_seen != 0) begin
                errors++;
                $display("FAIL cpl_block_req: %0d wr strobes during hold expected 0", wr_seen);
            end
            tick();
            bus.i_req_valid = 1'b0;
            checks++;
            if (bus.o_user_wr_req !== 1'b1 || bus.o_user_addr !== 20'h00099
                || bus.o_user_data !== 32'hCAFE_0099) begin
                errors++;
                $display("FAIL cpl_pending_wr: wr=%b addr=%h data=%h expected 1 00099 cafe0099",
                         bus.o_user_wr_req, bus.o_user_addr, bus.o_user_data);
            end
            tick();
        end

        checks++;
        if (bus.o_timeout_cnt !== exp_to_cnt) begin
            errors++;
            $display("FAIL timeout_cnt: got %0d expected %0d", bus.o_timeout_cnt, exp_to_cnt);
        end
    endtask

    task automatic test_read_ack();
        run_read(20'h00020, 3, 32'h1234_5678, 0);
        run_read(20'h00021, 0, 32'h0BEE_F00D, 0);
    endtask

    task automatic test_timeout();
        run_read(20'h00030, -1, 32'h0, 0);
        repeat (4) tick();
        bus.i_user_rd_ack = 1'b1;
        bus.i_user_data   = 32'h5555_5555;
        tick();
        bus.i_user_rd_ack = 1'b0;
        repeat (3) begin
            checks++;
            if (bus.o_cpl_valid !== 1'b0 || bus.o_cpl_data !== 32'hDEAD_BEEF
                || bus.o_cpl_timeout !== 1'b1 || bus.o_user_rd_req !== 1'b0) begin
                errors++;
                $display("FAIL stale_ack: valid=%b data=%h to=%b rd=%b expected 0 deadbeef 1 0",
                         bus.o_cpl_valid, bus.o_cpl_data, bus.o_cpl_timeout, bus.o_user_rd_req);
            end
            tick();
        end
    endtask

    task automatic test_ack_at_expiry();
        run_read(20'h00031, TIMEOUT - 1, 32'h0000_00FF, 0);
    endtask

    task automatic test_cpl_backpressure();
        run_read(20'h00032, 5, 32'h7777_0032, 10);
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        bus.i_req_valid = 1'b1;
        bus.i_req_wr    = 1'b0;
        bus.i_req_addr  = 20'h00040;
        bus.i_req_data  = 32'h4040_4040;
        tick();
        bus.i_req_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        exp_to_cnt = 16'd0;
        checks++;
        if ({bus.o_req_ready, bus.o_cpl_valid, bus.o_user_wr_req, bus.o_user_rd_req,
             bus.o_cpl_timeout} !== 5'b0) begin
            errors++;
            $display("FAIL midrst_ctrl: ready,cpl_valid,wr,rd,timeout=%b%b%b%b%b expected 00000",
                     bus.o_req_ready, bus.o_cpl_valid, bus.o_user_wr_req,
                     bus.o_user_rd_req, bus.o_cpl_timeout);
        end
        checks++;
        if (bus.o_cpl_data !== 32'h0 || bus.o_user_addr !== 20'h0 || bus.o_user_data !== 32'h0
            || bus.o_timeout_cnt !== 16'h0) begin
            errors++;
            $display("FAIL midrst_data: cpl_data=%h addr=%h data=%h cnt=%h expected all 0",
                     bus.o_cpl_data, bus.o_user_addr, bus.o_user_data, bus.o_timeout_cnt);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < TIMEOUT + 4; i++) begin
            tick();
            if (bus.o_cpl_valid !== 1'b0 || bus.o_user_rd_req !== 1'b0
                || bus.o_user_wr_req !== 1'b0 || bus.o_req_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrst_quiet: %0d cycles with activity or not ready expected 0", bad);
        end
        do_write(20'h00050, 32'h0BAD_F00D);
        run_read(20'h00051, 2, 32'h5151_5151, 0);
    endtask

    initial begin
        bus.i_req_valid   = 1'b0;
        bus.i_req_wr      = 1'b0;
        bus.i_req_addr    = '0;
        bus.i_req_data    = '0;
        bus.i_cpl_ready   = 1'b0;
        bus.i_user_data   = '0;
        bus.i_user_rd_ack = 1'b0;

        test_reset();
        test_write();
        test_back_to_back();
        test_read_ack();
        test_timeout();
        test_ack_at_expiry();
        test_cpl_backpressure();
        test_reset_mid();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
